// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_unit
// Brief    : Iterative radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//            signed/unsigned. Optional macro MULT_EARLY_EXIT_EN ends RUN early.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               neg_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] res_q;

    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic [WIDTH-1:0]   mplier_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_d;
    logic               last_d;

    // Magnitudes; the most negative value maps onto itself, read as unsigned.
    assign abs_a_d  = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign abs_b_d  = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign mplier_d = mplier_q >> 1;
    assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod_d   = neg_q ? -acc_q : acc_q;

`ifdef MULT_EARLY_EXIT_EN
    assign last_d = (cnt_q == CW'(WIDTH - 1)) || (mplier_d == '0);
`else
    assign last_d = (cnt_q == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, abs_a_d};
                        mplier_q <= abs_b_d;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    res_q   <= prod_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign res_lo = res_q[WIDTH-1:0];
    assign res_hi = res_q[2*WIDTH-1:WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_unit
// Brief    : Self-checking bench for seq_mult_unit: cycle-level reference model
//            plus directed vectors with hand-computed products and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, done;
    logic [W-1:0] res_lo, res_hi;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .res_lo(res_lo), .res_hi(res_hi)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b, logic s);
        longint p;
        if (s) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Number of RUN cycles the operation must take.
    function automatic int run_cycles(logic [31:0] b, logic s);
`ifdef MULT_EARLY_EXIT_EN
        logic [31:0] m;
        int r;
        m = (s && b[31]) ? -b : b;
        r = 0;
        for (int i = 0; i < 32; i++) if (m[i]) r = i + 1;
        return (r == 0) ? 1 : r;
`else
        return W;
`endif
    endfunction

    // Edges from the start-sampling edge (inclusive) until done is visible.
    function automatic int lat_of(logic [31:0] b, logic s);
        return run_cycles(b, s) + 2;
    endfunction

    // Reference model: transaction-level countdown, not bit-level.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [63:0] m_res = '0, m_pend = '0;
    int          m_left = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy && start) begin
                m_busy <= 1'b1;
                m_pend <= ref_prod(op_a, op_b, is_signed);
                m_left <= run_cycles(op_b, is_signed);
            end else if (m_busy) begin
                if (m_left == 0) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (busy !== m_busy || done !== m_done || {res_hi, res_lo} !== m_res) begin
                errors++;
                $display("FAIL cycle_model t=%0t: busy=%b done=%b res=%h required busy=%b done=%b res=%h",
                         $time, busy, done, {res_hi, res_lo}, m_busy, m_done, m_res);
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic start_op(logic [31:0] a, logic [31:0] b, logic s);
        op_a = a; op_b = b; is_signed = s; start = 1'b1;
    endtask

    // Waits for done; optionally pulses a competing start at edge pulse_at.
    task automatic wait_done(string name, logic [31:0] ehi, logic [31:0] elo,
                             int elat, int pulse_at);
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            n++;
            #1;
            if (n == 1) begin start = 1'b0; op_a = 32'hDEAD_BEEF; end
            if (pulse_at != 0 && n == pulse_at) start_op(32'd9, 32'd9, 1'b0);
            if (pulse_at != 0 && n == pulse_at + 1) start = 1'b0;
            if (done === 1'b1) break;
            if (n > 200) begin
                errors++;
                $display("FAIL %s_timeout: got no done after %0d edges required %0d", name, n, elat);
                return;
            end
        end
        check({name, "_lat"}, 64'(n), 64'(elat));
        check({name, "_res"}, {res_hi, res_lo}, {ehi, elo});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {60'b0, busy, done, |res_lo, |res_hi}, 64'b0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        start_op(32'd7, 32'd6, 1'b0);
        wait_done("u7x6", 32'h0, 32'h0000_002A, lat_of(32'd6, 1'b0), 0);
`ifndef MULT_EARLY_EXIT_EN
        checks++;
        if (lat_of(32'd6, 1'b0) != 34) begin errors++; $display("FAIL lat_model: got %0d required 34", lat_of(32'd6, 1'b0)); end
`endif
        start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        wait_done("s_m3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, lat_of(32'd5, 1'b1), 0);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("u_max", 32'hFFFF_FFFE, 32'h0000_0001, lat_of(32'hFFFF_FFFF, 1'b0), 0);
        start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_done("s_min", 32'h4000_0000, 32'h0, lat_of(32'h8000_0000, 1'b1), 0);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("s_m1", 32'h0, 32'h1, lat_of(32'hFFFF_FFFF, 1'b1), 0);
        start_op(32'h8000_0001, 32'h8000_0000, 1'b0);
        wait_done("u_msb", 32'h4000_0000, 32'h8000_0000, lat_of(32'h8000_0000, 1'b0), 0);
        start_op(32'd3, 32'd4, 1'b0);
        wait_done("ignored_start", 32'h0, 32'd12, lat_of(32'd4, 1'b0), 10);
        start_op(32'd2, 32'd3, 1'b0);
        wait_done("b2b_first", 32'h0, 32'd6, lat_of(32'd3, 1'b0), 0);
        start_op(32'd5, 32'hFFFF_FFFE, 1'b1);
        wait_done("b2b_second", 32'hFFFF_FFFF, 32'hFFFF_FFF6, lat_of(32'hFFFF_FFFE, 1'b1), 0);
        start_op(32'h1234_5678, 32'd0, 1'b0);
        wait_done("b_zero", 32'h0, 32'h0, lat_of(32'd0, 1'b0), 0);
        start_op(32'd3, 32'd5, 1'b0);
        wait_done("u3x5", 32'h0, 32'd15, lat_of(32'd5, 1'b0), 0);
`ifdef MULT_EARLY_EXIT_EN
        checks++;
        if (lat_of(32'd0, 1'b0) != 3 || lat_of(32'd5, 1'b0) != 5) begin
            errors++; $display("FAIL early_lat_model: got %0d/%0d required 3/5", lat_of(32'd0, 1'b0), lat_of(32'd5, 1'b0));
        end
`endif

        // Abort mid-operation: no done afterwards, outputs cleared.
        start_op(32'd7, 32'd6, 1'b0);
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_state", {60'b0, busy, done, |res_lo, |res_hi}, 64'b0);
        rst_n = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
            check("abort_no_done", 64'(seen), 64'b0);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
